// File: rtl/sdr_pkg.sv
// sdr_pkg: shared constants and types for the LVDS I/Q receive path.
// Sync patterns, sample width and the word assembler state type.
package sdr_pkg;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;
  localparam int         IQ_W   = 13;

  typedef enum logic [2:0] {
    HUNT,
    I_LO,
    Q_HI,
    Q_LO,
    I_HI
  } asm_state_e;

endpackage

// File: rtl/iq_out_reg.sv
// iq_out_reg: one-entry valid/ready holding register for an I/Q pair.
// Ports: load_i/i_i/q_i load a pair, ready_i drains it, valid_o/i_o/q_o hold it.
module iq_out_reg
  import sdr_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [IQ_W-1:0] i_i,
  input  logic [IQ_W-1:0] q_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [IQ_W-1:0] i_o,
  output logic [IQ_W-1:0] q_o
);

  logic            valid_q, valid_d;
  logic [IQ_W-1:0] i_q, i_d;
  logic [IQ_W-1:0] q_q, q_d;

  // A load in the same cycle as a handshake keeps valid with new data.
  always_comb begin
    valid_d = valid_q & ~ready_i;
    i_d     = i_q;
    q_d     = q_q;
    if (load_i) begin
      valid_d = 1'b1;
      i_d     = i_i;
      q_d     = q_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
    end else begin
      valid_q <= valid_d;
      i_q     <= i_d;
      q_q     <= q_d;
    end
  end

  assign valid_o = valid_q;
  assign i_o     = i_q;
  assign q_o     = q_q;

endmodule

// File: rtl/iq_word_assembler.sv
// iq_word_assembler: rebuilds 32-bit LVDS I/Q words from a byte FIFO,
// checks sync bits, tracks alignment lock and emits 13-bit I/Q pairs.
// Ports: clk, reset (sync, high); rd_dr/rd_en/rd_data FIFO pop side;
// out_valid/out_ready/out_i/out_q sample handshake; locked; err_count.
// Macro IQ_ERR_CNT_EN enables the saturating sync error counter.
module iq_word_assembler #(
  parameter int unsigned LOCK_WORDS = 4,
  parameter logic [1:0]  I_SYNC     = sdr_pkg::I_SYNC,
  parameter logic [1:0]  Q_SYNC     = sdr_pkg::Q_SYNC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_dr,
  output logic                     rd_en,
  input  logic [7:0]               rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [sdr_pkg::IQ_W-1:0] out_i,
  output logic [sdr_pkg::IQ_W-1:0] out_q,
  output logic                     locked,
  output logic [15:0]              err_count
);
  import sdr_pkg::*;

  localparam logic [7:0] LW8 = LOCK_WORDS[7:0];

  asm_state_e      state_q, state_d;
  logic [IQ_W-1:0] i_q, i_d;
  logic [5:0]      qh_q, qh_d;
  logic [7:0]      good_q, good_d;
  logic            locked_q, locked_d;
  logic            inflight_q;
  logic            stall;
  logic            load;
  logic            sync_err;
  logic            unused_ctrl;

  assign unused_ctrl = rd_data[0];

  // Hold off only the Q_LO fetch while the output is still occupied.
  assign stall = out_valid & ~out_ready & (state_q == Q_LO);
  assign rd_en = ~reset & rd_dr & ~inflight_q & ~stall;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    qh_d     = qh_q;
    good_d   = good_q;
    load     = 1'b0;
    sync_err = 1'b0;
    if (inflight_q) begin
      unique case (state_q)
        HUNT, I_HI: begin
          if (rd_data[7:6] == I_SYNC) begin
            i_d[IQ_W-1:7] = rd_data[5:0];
            state_d       = I_LO;
          end else begin
            sync_err = (state_q == I_HI);
            state_d  = HUNT;
          end
        end
        I_LO: begin
          i_d[6:0] = rd_data[7:1];
          state_d  = Q_HI;
        end
        Q_HI: begin
          if (rd_data[7:6] == Q_SYNC) begin
            qh_d    = rd_data[5:0];
            state_d = Q_LO;
          end else begin
            sync_err = 1'b1;
            // A slipped word may start right here: reuse as I_HI.
            if (rd_data[7:6] == I_SYNC) begin
              i_d[IQ_W-1:7] = rd_data[5:0];
              state_d       = I_LO;
            end else begin
              state_d = HUNT;
            end
          end
        end
        Q_LO: begin
          load = 1'b1;
          if (good_q != LW8) good_d = good_q + 8'd1;
          state_d = I_HI;
        end
        default: state_d = HUNT;
      endcase
      if (sync_err) good_d = '0;
    end
  end

  assign locked_d = (good_d == LW8);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      i_q        <= '0;
      qh_q       <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      qh_q       <= qh_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      inflight_q <= rd_en;
    end
  end

  assign locked = locked_q;

  iq_out_reg u_out (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .i_i     (i_q),
    .q_i     ({qh_q, rd_data[7:1]}),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .i_o     (out_i),
    .q_o     (out_q)
  );

`ifdef IQ_ERR_CNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (sync_err && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/iq_word_assembler.md
Name: iq_word_assembler

Overview:
- Consumes the byte stream from the LVDS Deserializer output FIFO and rebuilds 32-bit I/Q words in the transceiver LVDS format.
- Checks the sync bits on every word, extracts the 13-bit signed I and Q samples, and presents them on a valid/ready handshake to the DSP chain (decimator/NCO).
- Sits directly downstream of the Deserializer, in the `clk` domain.

Parameters:
- LOCK_WORDS, 4: consecutive good words required before `locked` asserts (range 1..255).
- I_SYNC, 2'b10: required value of bits [7:6] of the I high byte.
- Q_SYNC, 2'b01: required value of bits [7:6] of the Q high byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- rd_dr  in  1  FIFO holds at least one byte.
- rd_en  out  1  one-cycle pop request to the FIFO.
- rd_data  in  8  popped byte; valid exactly one cycle after `rd_en`.
- out_valid  out  1  sample pair held in the output register.
- out_ready  in  1  consumer accepts when `out_valid && out_ready`.
- out_i  out  13  I sample, two's complement.
- out_q  out  13  Q sample, two's complement.
- locked  out  1  word alignment established.
- err_count  out  16  sync error count (optional feature).

Behaviour:
- Single clock `clk`; reset is synchronous and active-high.
- Reset values:
  - `rd_en`, `out_valid`, `locked` = 0.
  - `out_i`, `out_q`, `err_count` = 0.
  - State = HUNT, good-word counter = 0, read-in-flight flag = 0.
- Reset mid-word discards the partial word. A read already in flight is dropped: the byte arriving next cycle is ignored.
- Word byte order is MSB first:
  - I_HI = {I_SYNC, I[12:7]}
  - I_LO = {I[6:0], ctrl_i}
  - Q_HI = {Q_SYNC, Q[12:7]}
  - Q_LO = {Q[6:0], ctrl_q}
  - ctrl bits are ignored.
- Read rule: `rd_en` = `rd_dr` && !inflight && !stall. At most one outstanding read, so throughput is one byte per 2 clk. `clk` must be at least 2x the byte rate.
- stall = `out_valid` && !`out_ready` && (state == Q_LO). Bytes for a following word may be fetched up to Q_LO while the output is still occupied.
- States (advance only on an arriving byte, i.e. the cycle after `rd_en`):
  - HUNT: byte[7:6]==I_SYNC → latch I[12:7], go I_LO; otherwise stay and count no error.
  - I_LO: latch I[6:0] → Q_HI.
  - Q_HI: byte[7:6]==Q_SYNC → latch Q[12:7], go Q_LO. Otherwise sync error:
    - clear `locked` and the good counter;
    - go I_LO if byte[7:6]==I_SYNC (byte reused as I_HI), else HUNT.
  - Q_LO: load `out_i`/`out_q`, set `out_valid`, good counter += 1 (saturating at LOCK_WORDS), go I_HI.
  - I_HI: as HUNT, except a non-sync byte is a sync error (same action as in Q_HI).
- `locked` rises in the same cycle the good counter reaches LOCK_WORDS.
- Output register: `out_valid` clears on handshake. A simultaneous handshake and Q_LO load keeps `out_valid`=1 with the new data.
- `out_i`/`out_q` are stable while `out_valid` && !`out_ready`.

Optional Feature:
- Macro `IQ_ERR_CNT_EN`.
- Defined: `err_count` increments by 1 on each sync error, saturates at 16'hFFFF, and clears only on reset.
- Undefined: no counter logic; `err_count` is tied to 0.

Decomposition:
- Shared package `sdr_pkg` holds I_SYNC/Q_SYNC constants, the state enum (HUNT, I_LO, Q_HI, Q_LO, I_HI), and the sample width constant IQ_W=13.
- One sub-module, `iq_out_reg`: a one-entry valid/ready holding register for {`out_i`, `out_q`}.

Test Plan:
- Clean stream: bytes 0x80,0x02,0x40,0x02 → one beat with `out_i`=1, `out_q`=1. Words 2..4 repeated → `locked`=1 after the 4th beat.
- Garbage then sync: 0x00,0x3F,0xFF, then a valid word with I=-1, Q=-4096 (0xBF,0xFE,0x60,0x00) → `out_i`=13'h1FFF, `out_q`=13'h1000, `err_count`=0.
- Slip while locked: Q_HI replaced by 0x85 → `locked`=0, `err_count`=1. 0x85 is reused as I_HI; the next good word completes the resync.
- Backpressure: hold `out_ready`=0 for 20 cycles with `rd_dr`=1 → exactly one word pending, `rd_en` stops at Q_LO, `out_i`/`out_q` stable. On release, no loss and no duplication.
- `rd_dr` toggling every other cycle → `rd_en` never asserted with an outstanding read, and all words are reassembled in order.
- Assert `reset` during Q_HI with a read in flight → outputs return to reset values, and the late byte is not consumed as I_HI.
